// File: rtl/rv_pkg.sv
// Shared RV32I control definitions: opcodes, immediate formats, mux codes, FSM states.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned IMMSEL_W = 3;
  localparam int unsigned CLS_W    = 4;

  // Base opcodes (ir[6:0])
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  // Immediate generator format select
  localparam logic [IMMSEL_W-1:0] IMMSEL_U    = 3'b000;
  localparam logic [IMMSEL_W-1:0] IMMSEL_J    = 3'b001;
  localparam logic [IMMSEL_W-1:0] IMMSEL_I    = 3'b010;
  localparam logic [IMMSEL_W-1:0] IMMSEL_B    = 3'b011;
  localparam logic [IMMSEL_W-1:0] IMMSEL_S    = 3'b100;
  localparam logic [IMMSEL_W-1:0] IMMSEL_NONE = 3'b111;

  // PC source select
  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_IMM  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;

  // Write-back source select
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  // Instruction class produced by the opcode decoder
  localparam logic [CLS_W-1:0] CLS_ILLEGAL = 4'd0;
  localparam logic [CLS_W-1:0] CLS_LUI     = 4'd1;
  localparam logic [CLS_W-1:0] CLS_AUIPC   = 4'd2;
  localparam logic [CLS_W-1:0] CLS_JAL     = 4'd3;
  localparam logic [CLS_W-1:0] CLS_JALR    = 4'd4;
  localparam logic [CLS_W-1:0] CLS_BRANCH  = 4'd5;
  localparam logic [CLS_W-1:0] CLS_LOAD    = 4'd6;
  localparam logic [CLS_W-1:0] CLS_STORE   = 4'd7;
  localparam logic [CLS_W-1:0] CLS_OPIMM   = 4'd8;
  localparam logic [CLS_W-1:0] CLS_OP      = 4'd9;
  localparam logic [CLS_W-1:0] CLS_FENCE   = 4'd10;
  localparam logic [CLS_W-1:0] CLS_SYSTEM  = 4'd11;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/rv_opdec.sv
// Opcode decoder: maps ir[6:0] to immediate format, instruction class and legality.
module rv_opdec
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] immsel,
  output logic [3:0] cls,
  output logic       legal
);

  // Pure lookup; unknown opcodes fall through to the illegal defaults
  always_comb begin
    immsel = IMMSEL_NONE;
    cls    = CLS_ILLEGAL;
    legal  = 1'b0;
    case (opcode)
      OPC_LUI:    begin immsel = IMMSEL_U;    cls = CLS_LUI;    legal = 1'b1; end
      OPC_AUIPC:  begin immsel = IMMSEL_U;    cls = CLS_AUIPC;  legal = 1'b1; end
      OPC_JAL:    begin immsel = IMMSEL_J;    cls = CLS_JAL;    legal = 1'b1; end
      OPC_JALR:   begin immsel = IMMSEL_I;    cls = CLS_JALR;   legal = 1'b1; end
      OPC_LOAD:   begin immsel = IMMSEL_I;    cls = CLS_LOAD;   legal = 1'b1; end
      OPC_OPIMM:  begin immsel = IMMSEL_I;    cls = CLS_OPIMM;  legal = 1'b1; end
      OPC_BRANCH: begin immsel = IMMSEL_B;    cls = CLS_BRANCH; legal = 1'b1; end
      OPC_STORE:  begin immsel = IMMSEL_S;    cls = CLS_STORE;  legal = 1'b1; end
      OPC_OP:     begin immsel = IMMSEL_NONE; cls = CLS_OP;     legal = 1'b1; end
      OPC_FENCE:  begin immsel = IMMSEL_NONE; cls = CLS_FENCE;  legal = 1'b1; end
      OPC_SYSTEM: begin immsel = IMMSEL_NONE; cls = CLS_SYSTEM; legal = 1'b1; end
      default:    ;
    endcase
  end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB.
module rv_ctrl_fsm
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic [2:0]  immsel,
  output logic [31:0] pc_init,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        addr_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  logic [2:0]  dec_immsel;
  logic [3:0]  dec_cls;
  logic        dec_legal;

  // Only the opcode field steers control; remaining IR bits belong to the datapath
  logic unused_ir;
  assign unused_ir = ^ir[31:7];

  assign pc_init = RESET_PC;
  assign halted  = halted_q;
  assign illegal = illegal_q;

  rv_opdec u_opdec (
    .opcode (ir[6:0]),
    .immsel (dec_immsel),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  // Next state, sticky stop flags and control outputs from state and decoded opcode
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    immsel    = IMMSEL_NONE;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = 1'b0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    pc_sel    = PC_SEL_PC4;
    wb_sel    = WB_SEL_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        immsel = dec_immsel;
        if (!dec_legal) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else if (dec_cls == CLS_SYSTEM) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        immsel = dec_immsel;
        case (dec_cls)
          CLS_OP:    state_d = ST_WB;
          CLS_OPIMM: begin alu_b_sel = 1'b1; state_d = ST_WB; end
          CLS_LUI:   begin wb_sel = WB_SEL_IMM; state_d = ST_WB; end
          CLS_AUIPC: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; state_d = ST_WB; end
          CLS_JAL,
          CLS_JALR:  begin wb_sel = WB_SEL_PC4; state_d = ST_WB; end
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_SEL_IMM : PC_SEL_PC4;
            state_d = ST_FETCH;
          end
          CLS_LOAD,
          CLS_STORE: begin alu_b_sel = 1'b1; state_d = ST_MEM; end
          CLS_FENCE: begin pc_we = 1'b1; pc_sel = PC_SEL_PC4; state_d = ST_FETCH; end
          default:   state_d = ST_HALT;
        endcase
      end

      ST_MEM: begin
        immsel    = dec_immsel;
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        alu_b_sel = 1'b1;
        mem_wr    = (dec_cls == CLS_STORE);
        if (mem_ready) begin
          if (dec_cls == CLS_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_SEL_PC4;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        immsel  = dec_immsel;
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        // ALU operand selects stay put so the result being written is stable
        case (dec_cls)
          CLS_LOAD:  wb_sel = WB_SEL_MEM;
          CLS_LUI:   wb_sel = WB_SEL_IMM;
          CLS_JAL:   begin wb_sel = WB_SEL_PC4; pc_sel = PC_SEL_IMM; end
          CLS_JALR:  begin wb_sel = WB_SEL_PC4; pc_sel = PC_SEL_JALR; end
          CLS_AUIPC: begin alu_a_sel = 1'b1; alu_b_sel = 1'b1; end
          CLS_OPIMM: alu_b_sel = 1'b1;
          default:   ;
        endcase
      end

      ST_HALT: ;

      default: state_d = ST_FETCH;
    endcase

    // Reset cycle: withdraw any request and block every write
    if (rst) begin
      immsel    = IMMSEL_NONE;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      addr_sel  = 1'b0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      pc_sel    = PC_SEL_PC4;
      wb_sel    = WB_SEL_ALU;
    end
  end

  // State and stop-flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Scoreboard bench for rv_ctrl_fsm: per-instruction cycle traces from an opcode-level model.
module tb_rv_ctrl_fsm;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [2:0] immsel;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic       mem_req;
    logic       mem_wr;
    logic       addr_sel;
    logic       alu_a;
    logic       alu_b;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       halted;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    obs_t       v;
    obs_t       m;
    logic [7:0] ph;
  } exp_t;

  localparam int K_OP = 0, K_OPIMM = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4, K_JALR = 5,
                 K_BR = 6, K_LD = 7, K_ST = 8, K_FENCE = 9, K_SYS = 10, K_ILL = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        mem_ready;
  logic        br_taken;
  logic [2:0]  immsel;
  logic [31:0] pc_init;
  logic        ir_we, pc_we, rf_we, mem_req, mem_wr;
  logic        addr_sel, alu_a_sel, alu_b_sel;
  logic [1:0]  pc_sel, wb_sel;
  logic        halted, illegal;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic m_halted  = 1'b0;
  logic m_illegal = 1'b0;

  always #5 clk = ~clk;

  rv_ctrl_fsm #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready), .br_taken(br_taken),
    .immsel(immsel), .pc_init(pc_init), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .mem_req(mem_req), .mem_wr(mem_wr), .addr_sel(addr_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .pc_sel(pc_sel), .wb_sel(wb_sel), .halted(halted),
    .illegal(illegal)
  );

  // Monitor: one expected record per presented cycle, compared under its mask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      obs_t a;
      e = sb.pop_front();
      a = '{immsel, ir_we, pc_we, rf_we, mem_req, mem_wr, addr_sel, alu_a_sel,
            alu_b_sel, pc_sel, wb_sel, halted, illegal};
      total++;
      if ((((a ^ e.v) & e.m) !== '0) || (pc_init !== RESET_PC)) begin
        bad++;
        $display("FAIL %c-cycle #%0d: got %h want %h (mask %h) pc_init=%h",
                 e.ph, total, a, e.v, e.m, pc_init);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] rw();
    return 32'($urandom());
  endfunction

  // Default expectation: no enables, no request, flags as the model holds them
  function automatic exp_t base(input logic [7:0] ph);
    exp_t e;
    e.v         = '0;
    e.v.immsel  = 3'b111;
    e.v.halted  = m_halted;
    e.v.illegal = m_illegal;
    e.m         = '0;
    e.m.ir_we   = 1'b1;
    e.m.pc_we   = 1'b1;
    e.m.rf_we   = 1'b1;
    e.m.mem_req = 1'b1;
    e.m.mem_wr  = 1'b1;
    e.m.halted  = 1'b1;
    e.m.illegal = 1'b1;
    e.ph        = ph;
    return e;
  endfunction

  task automatic classify(input logic [6:0] opc, output int k, output logic [2:0] imm);
    case (opc)
      7'h37: begin k = K_LUI;   imm = 3'b000; end
      7'h17: begin k = K_AUIPC; imm = 3'b000; end
      7'h6F: begin k = K_JAL;   imm = 3'b001; end
      7'h67: begin k = K_JALR;  imm = 3'b010; end
      7'h03: begin k = K_LD;    imm = 3'b010; end
      7'h13: begin k = K_OPIMM; imm = 3'b010; end
      7'h63: begin k = K_BR;    imm = 3'b011; end
      7'h23: begin k = K_ST;    imm = 3'b100; end
      7'h33: begin k = K_OP;    imm = 3'b111; end
      7'h0F: begin k = K_FENCE; imm = 3'b111; end
      7'h73: begin k = K_SYS;   imm = 3'b111; end
      default: begin k = K_ILL; imm = 3'b111; end
    endcase
  endtask

  task automatic cyc(input exp_t e, input logic r, input logic mr, input logic bt,
                     input logic [31:0] irv);
    rst       = r;
    mem_ready = mr;
    br_taken  = bt;
    ir        = irv;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cyc();
    exp_t e;
    e          = base("R");
    e.m.immsel = 3'b111;
    cyc(e, 1'b1, rb(), rb(), rw());
    m_halted  = 1'b0;
    m_illegal = 1'b0;
  endtask

  // One whole instruction; abort_mw >= 0 replaces that MEM wait cycle with a reset
  task automatic do_instr(input logic [31:0] instr, input int fw, input int mw,
                          input logic bt, input int abort_mw);
    exp_t e;
    int k;
    logic [2:0] imm;
    classify(instr[6:0], k, imm);

    for (int i = 0; i < fw; i++) begin
      e = base("F"); e.v.mem_req = 1'b1; e.m.addr_sel = 1'b1;
      cyc(e, 1'b0, 1'b0, rb(), rw());
    end
    e = base("F"); e.v.mem_req = 1'b1; e.m.addr_sel = 1'b1; e.v.ir_we = 1'b1;
    cyc(e, 1'b0, 1'b1, rb(), rw());

    e = base("D"); e.v.immsel = imm; e.m.immsel = 3'b111;
    cyc(e, 1'b0, rb(), rb(), instr);

    if (k == K_SYS || k == K_ILL) begin
      if (k == K_SYS) m_halted = 1'b1;
      else            m_illegal = 1'b1;
      for (int i = 0; i < 3; i++) begin
        e = base("H");
        cyc(e, 1'b0, 1'b1, rb(), instr);
      end
      return;
    end

    e = base("E"); e.v.immsel = imm; e.m.immsel = 3'b111;
    case (k)
      K_OP:    begin e.m.alu_a = 1'b1; e.m.alu_b = 1'b1; end
      K_OPIMM: begin e.m.alu_a = 1'b1; e.m.alu_b = 1'b1; e.v.alu_b = 1'b1; end
      K_AUIPC: begin e.m.alu_a = 1'b1; e.m.alu_b = 1'b1; e.v.alu_a = 1'b1; e.v.alu_b = 1'b1; end
      K_LD, K_ST: begin e.m.alu_a = 1'b1; e.m.alu_b = 1'b1; e.v.alu_b = 1'b1; end
      K_BR:    begin e.v.pc_we = 1'b1; e.m.pc_sel = 2'b11; e.v.pc_sel = bt ? 2'b01 : 2'b00; end
      K_FENCE: begin e.v.pc_we = 1'b1; e.m.pc_sel = 2'b11; end
      default: ;
    endcase
    cyc(e, 1'b0, rb(), (k == K_BR) ? bt : rb(), instr);
    if (k == K_BR || k == K_FENCE) return;

    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == abort_mw) begin
          rst_cyc();
          return;
        end
        e = base("M"); e.v.immsel = imm; e.m.immsel = 3'b111;
        e.v.mem_req = 1'b1; e.v.addr_sel = 1'b1; e.m.addr_sel = 1'b1;
        e.v.alu_b = 1'b1; e.m.alu_b = 1'b1; e.v.mem_wr = (k == K_ST);
        if (i == mw && k == K_ST) begin
          e.v.pc_we = 1'b1; e.m.pc_sel = 2'b11;
        end
        cyc(e, 1'b0, (i == mw), rb(), instr);
      end
      if (k == K_ST) return;
    end

    e = base("W"); e.v.immsel = imm; e.m.immsel = 3'b111;
    e.v.rf_we = 1'b1; e.m.wb_sel = 2'b11; e.v.pc_we = 1'b1; e.m.pc_sel = 2'b11;
    case (k)
      K_LD:   e.v.wb_sel = 2'b01;
      K_LUI:  e.v.wb_sel = 2'b11;
      K_JAL:  begin e.v.wb_sel = 2'b10; e.v.pc_sel = 2'b01; end
      K_JALR: begin e.v.wb_sel = 2'b10; e.v.pc_sel = 2'b10; end
      default: ;
    endcase
    cyc(e, 1'b0, rb(), rb(), instr);
  endtask

  logic [6:0] legal_ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  initial begin
    rst = 1'b1; mem_ready = 1'b1; br_taken = 1'b0; ir = 32'h0;
    @(posedge clk);
    #1;
    rst_cyc();
    rst_cyc();

    do_instr(32'h00500093, 0, 0, 1'b0, -1);  // ADDI x1,x0,5
    do_instr(32'h0000A103, 0, 3, 1'b0, -1);  // LW with 3 MEM waits
    do_instr(32'h00208463, 0, 0, 1'b1, -1);  // BEQ taken
    do_instr(32'h00208463, 1, 0, 1'b0, -1);  // BEQ not taken, fetch wait
    do_instr(32'h000080E7, 0, 0, 1'b0, -1);  // JALR
    do_instr(32'h00112023, 0, 2, 1'b0, -1);  // SW
    do_instr(32'h123450B7, 0, 0, 1'b0, -1);  // LUI
    do_instr(32'h00001097, 2, 0, 1'b0, -1);  // AUIPC
    do_instr(32'h008000EF, 0, 0, 1'b0, -1);  // JAL
    do_instr(32'h002081B3, 0, 0, 1'b0, -1);  // ADD
    do_instr(32'h0FF0000F, 0, 0, 1'b0, -1);  // FENCE
    do_instr(32'h0000A103, 0, 3, 1'b0, 1);   // LW aborted by reset in MEM

    for (int n = 0; n < 200; n++) begin
      logic [31:0] instr;
      instr = (rw() & 32'hFFFF_FF80) | {25'b0, legal_ops[$urandom_range(0, 8)]};
      do_instr(instr, $urandom_range(0, 2), $urandom_range(0, 3), rb(), -1);
    end

    do_instr(32'h00000073, 0, 0, 1'b0, -1);  // ECALL
    rst_cyc();
    do_instr(32'h00100073, 1, 0, 1'b0, -1);  // EBREAK
    rst_cyc();
    do_instr(32'hFFFFFFFF, 0, 0, 1'b0, -1);  // illegal opcode
    rst_cyc();
    do_instr(32'h00500093, 0, 0, 1'b0, -1);  // resumes normally after reset

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending records want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_ctrl_fsm.md
# rv_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back. It drives the immediate-generator select, the register/PC/IR write enables, the memory request handshake and the datapath muxes from the opcode held in the external instruction register. It sits between the instruction/data memory interface and the datapath (register file, immediate generator, ALU, branch comparator).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value driven on `pc_init` while `rst` is high; the datapath loads it into the PC.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ir  in  32  current instruction from the external IR; only valid after FETCH completes
- mem_ready  in  1  memory accepted the request or returned data this cycle
- br_taken  in  1  branch-comparator result for the current ir[14:12]
- immsel  out  3  immediate format: U=000, J=001, I=010, B=011, S=100, none=111
- pc_init  out  32  RESET_PC
- ir_we, pc_we, rf_we  out  1 each  write enables
- mem_req, mem_wr  out  1 each  memory request; write qualifier
- addr_sel  out  1  memory address source: 0=PC, 1=ALU result
- alu_a_sel  out  1  ALU A source: 0=rs1, 1=PC
- alu_b_sel  out  1  ALU B source: 0=rs2, 1=immediate
- pc_sel  out  2  PC source: 00=PC+4, 01=PC+imm, 10=(rs1+imm)&~1
- wb_sel  out  2  write-back source: 00=ALU, 01=load data, 10=PC+4, 11=immediate
- halted  out  1  core stopped on ECALL/EBREAK
- illegal  out  1  core stopped on an unknown opcode

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encodings are state constants in the package.
- FETCH
  - Drive mem_req=1, addr_sel=0, mem_wr=0.
  - On mem_ready: ir_we=1, go to DECODE.
  - Otherwise hold, with mem_req kept at 1.
- DECODE
  - Decode opcode ir[6:0] and drive immsel from it. immsel stays valid from DECODE through the instruction's last state.
  - Opcode → immsel: LUI/AUIPC→U; JAL→J; JALR/LOAD/OP-IMM→I; BRANCH→B; STORE→S; OP/FENCE/SYSTEM→none.
  - SYSTEM (ECALL/EBREAK) → HALT with halted=1. An unlisted opcode → HALT with illegal=1. All others → EXEC.
- EXEC, per opcode:
  - OP and OP-IMM: alu_b_sel=1 for OP-IMM only. Go to WB.
  - LUI: go to WB with wb_sel=11.
  - AUIPC: alu_a_sel=1, alu_b_sel=1. Go to WB.
  - JAL/JALR: go to WB with wb_sel=10. The PC update happens in WB.
  - BRANCH: pc_we=1. pc_sel=01 if br_taken, else 00. Go to FETCH.
  - LOAD/STORE: alu_b_sel=1. Go to MEM.
  - FENCE: pc_we=1, pc_sel=00. Go to FETCH (treated as a NOP).
- MEM
  - Drive mem_req=1, addr_sel=1, alu_b_sel=1; mem_wr=1 for STORE.
  - Hold until mem_ready.
  - On mem_ready: LOAD → WB. STORE → FETCH with pc_we=1, pc_sel=00.
- WB
  - rf_we=1, plus wb_sel per opcode (LOAD=01).
  - pc_we=1 with pc_sel: JAL=01, JALR=10, others=00.
  - Go to FETCH.
  - rf_we is asserted even when rd=x0; the register file ignores x0 writes.
- HALT: absorbing state. All enables are 0. Only rst leaves it.
- All enables, mem_req and mem_wr are combinational from state and ir. They are 0 in any state not listed above.

## Timing
- Reset, while rst=1 at a rising edge:
  - Next state is FETCH, halted=0, illegal=0.
  - All enables, mem_req and mem_wr are forced to 0 during the rst cycle. immsel=111.
- rst mid-operation (e.g. in MEM with mem_ready pending) drops the access with no writes. Memory must tolerate withdrawal of mem_req.
- Minimum CPI with mem_ready=1 every cycle:
  - BRANCH/FENCE: 3 cycles (FETCH, DECODE, EXEC).
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles. LOAD: 5 cycles.
  - Each wait cycle on mem_ready adds one.
- mem_ready sampled outside FETCH/MEM is ignored.
- halted and illegal are registered and set on the DECODE→HALT edge. They are never both 1.
- br_taken is sampled only in EXEC of a BRANCH.

## Structure
- Shared package `rv_pkg`: opcode localparams, IMMSEL_* codes (U, J, I, B, S, NONE), state encoding, PC_SEL_* and WB_SEL_* codes. The immediate generator and this block both import these.
- One sub-module, `rv_opdec`: combinational opcode → {immsel, class, legal}. The FSM instantiates it; the rest is the state register plus output logic.

## Test plan
- Reset: hold rst 2 cycles with mem_ready=1 → all enables 0, immsel=111, halted=0. First post-reset cycle is FETCH with mem_req=1, addr_sel=0.
- ADDI x1,x0,5 (0x00500093), mem_ready=1 → exactly 4 cycles. immsel=010 in DECODE/EXEC/WB; rf_we=1 only in WB with wb_sel=00; pc_we=1 with pc_sel=00 in WB.
- LW (0x0000A103), mem_ready low for 3 MEM cycles → MEM held 4 cycles with mem_req=1, addr_sel=1, mem_wr=0. WB then gives rf_we=1, wb_sel=01. 8 cycles total.
- BEQ (0x00208463): br_taken=1 → immsel=011, pc_sel=01, pc_we=1 in EXEC, rf_we never 1. Repeat with br_taken=0 → pc_sel=00.
- JALR (0x000080E7) → immsel=010; WB has rf_we=1, wb_sel=10, pc_sel=10. SW (0x00112023) → immsel=100; MEM has mem_wr=1; no rf_we.
- ir=0x00000073 → HALT, halted=1, no further mem_req. ir=0xFFFFFFFF → HALT, illegal=1. A rst pulse in HALT returns the FSM to FETCH with both flags cleared.
